// File: rtl/cgra_obi_master_slice.sv
// cgra_obi_master_slice: per-master-port OBI register slice between one CGRA
// TCDM master port and the system bus.
//  - Request path: FIFO_DEPTH-entry buffer. Grant towards the CGRA depends only
//    on registered state, which breaks the combinational gnt path from the bus.
//  - Response path: rvalid/rdata are registered once; rdata holds between beats.
//  - Outstanding cap: at most MAX_OUTSTANDING accepted requests may be waiting
//    for their rvalid. Responses must return in grant order (no ID tracking).
//  - Optional feature macro CGRA_OBI_SLICE_PERF_EN: when defined, a saturating
//    32-bit counter of bus-side stall cycles drives perf_stall_cnt_o; when
//    undefined, that output is tied to zero and no counter flops exist.

package cgra_obi_pkg;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

module cgra_obi_master_slice
    import cgra_obi_pkg::*;
#(
    parameter int FIFO_DEPTH      = 2,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  obi_req_t    s_req_i,
    output obi_resp_t   s_resp_o,
    output obi_req_t    m_req_o,
    input  obi_resp_t   m_resp_i,
    output logic [3:0]  outstanding_o,
    output logic        idle_o,
    output logic        err_o,
    output logic [31:0] perf_stall_cnt_o
);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    localparam int               PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE = (PTR_W + 1)'(1);
    localparam logic [3:0]       MAX_CNT = 4'(MAX_OUTSTANDING);

    // One buffered request: everything the bus needs except the req strobe.
    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } entry_t;

    entry_t           mem_q [FIFO_DEPTH];
    entry_t           mem_d [FIFO_DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             fifo_empty;
    logic             fifo_full;
    logic             cap_ok;
    logic             s_gnt;
    logic             push;
    logic             pop;
    logic             rsp_dec;
    entry_t           head;
    entry_t           wr_entry;

    // FIFO status, grant and handshake qualifiers, all from registered state
    // except the request strobes themselves.
    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        cap_ok     = (cnt_q < MAX_CNT);
        s_gnt      = s_req_i.req & ~fifo_full & cap_ok;
        push       = s_req_i.req & s_gnt;
        pop        = ~fifo_empty & m_resp_i.gnt;
        // A stray rvalid (nothing outstanding) must not wrap the counter.
        rsp_dec    = m_resp_i.rvalid & (cnt_q != 4'd0);
        head       = mem_q[rd_ptr_q[PTR_W-1:0]];
        wr_entry.addr  = s_req_i.addr;
        wr_entry.we    = s_req_i.we;
        wr_entry.be    = s_req_i.be;
        wr_entry.wdata = s_req_i.wdata;
    end

    // Next-state for FIFO storage, pointers, outstanding count, response
    // register and sticky error flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        rvalid_d = m_resp_i.rvalid;
        rdata_d  = rdata_q;
        err_d    = err_q;

        if (push) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = wr_entry;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        // Accept and response in the same cycle cancel out.
        if (push && !rsp_dec) begin
            cnt_d = cnt_q + 4'd1;
        end else if (!push && rsp_dec) begin
            cnt_d = cnt_q - 4'd1;
        end

        if (m_resp_i.rvalid) begin
            rdata_d = m_resp_i.rdata;
        end
        if (m_resp_i.rvalid && (cnt_q == 4'd0)) begin
            err_d = 1'b1;
        end
    end

    // Control state: pointers, count, response valid/data and error flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= 4'd0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Request payload storage; validity is tracked by the pointers, so the
    // data itself needs no reset.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

`ifdef CGRA_OBI_SLICE_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Stall counter next-state: bus-side request waiting for grant, saturating.
    always_comb begin
        perf_d = perf_q;
        if (~fifo_empty && !m_resp_i.gnt && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Stall counter register, cleared only by reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= 32'd0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt_o = perf_q;
`else
    assign perf_stall_cnt_o = 32'd0;
`endif

    // Output assembly: bus request from FIFO head, registered response upstream.
    always_comb begin
        m_req_o        = '0;
        m_req_o.req    = ~fifo_empty;
        m_req_o.addr   = head.addr;
        m_req_o.we     = head.we;
        m_req_o.be     = head.be;
        m_req_o.wdata  = head.wdata;

        s_resp_o        = '0;
        s_resp_o.gnt    = s_gnt;
        s_resp_o.rvalid = rvalid_q;
        s_resp_o.rdata  = rdata_q;

        outstanding_o = cnt_q;
        idle_o        = fifo_empty & (cnt_q == 4'd0);
        err_o         = err_q;
    end

endmodule

// File: tb/tb_cgra_obi_master_slice.sv
// Testbench for cgra_obi_master_slice: randomized and directed traffic checked
// against a queue-based reference model of the slice and an in-order bus model.
module tb_cgra_obi_master_slice;
    import cgra_obi_pkg::*;

    localparam int FD = 2;
    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    obi_req_t    s_req;
    obi_resp_t   s_resp;
    obi_req_t    m_req;
    obi_resp_t   m_resp;
    logic [3:0]  outst;
    logic        idle;
    logic        err;
    logic [31:0] perf;

    always #5 clk = ~clk;

    cgra_obi_master_slice #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .s_req_i         (s_req),
        .s_resp_o        (s_resp),
        .m_req_o         (m_req),
        .m_resp_i        (m_resp),
        .outstanding_o   (outst),
        .idle_o          (idle),
        .err_o           (err),
        .perf_stall_cnt_o(perf)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } ent_t;

    // Reference model state
    ent_t        mq[$];      // requests accepted but not yet granted by the bus
    logic [31:0] bus_q[$];   // responses owed by the bus, in grant order
    logic [31:0] acc_q[$];   // responses owed to the CGRA, in accept order
    int          m_cnt;
    bit          m_err;
    bit          m_rvalid;
    logic [31:0] m_rdata;
    bit          m_stray;
    logic [31:0] m_perf;

    int n_chk = 0;
    int n_err = 0;
    bit last_gnt;

    function automatic logic [31:0] rsp_of(ent_t e);
        return e.addr ^ 32'h5A5A_0F0F ^ {28'h0, e.be};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        bus_q.delete();
        acc_q.delete();
        m_cnt    = 0;
        m_err    = 1'b0;
        m_rvalid = 1'b0;
        m_rdata  = 32'd0;
        m_stray  = 1'b0;
        m_perf   = 32'd0;
    endtask

    // One clock cycle: drive at negedge, check combinational and registered
    // outputs against the model, advance the model, then wait for next negedge.
    task automatic cycle(input bit req, input bit gnt, input bit rv_en,
                         input bit stray, input bit rd_only);
        ent_t        e;
        bit          exp_gnt;
        bit          do_rv;
        bit          from_bus;
        logic [31:0] rv_data;

        e.addr  = $urandom;
        e.we    = rd_only ? 1'b0 : 1'($urandom_range(0, 1));
        e.be    = 4'($urandom);
        e.wdata = $urandom;
        s_req.req   = req;
        s_req.addr  = e.addr;
        s_req.we    = e.we;
        s_req.be    = e.be;
        s_req.wdata = e.wdata;

        m_resp.gnt = gnt;
        do_rv    = 1'b0;
        from_bus = 1'b0;
        rv_data  = $urandom;
        if (rv_en && bus_q.size() > 0) begin
            do_rv    = 1'b1;
            from_bus = 1'b1;
            rv_data  = bus_q[0];
        end else if (stray) begin
            do_rv = 1'b1;
        end
        m_resp.rvalid = do_rv;
        m_resp.rdata  = rv_data;
        #1;

        exp_gnt  = req && (mq.size() < FD) && (m_cnt < MO);
        last_gnt = s_resp.gnt;
        chk("s_gnt", 32'(s_resp.gnt), 32'(exp_gnt));
        chk("m_req", 32'(m_req.req), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            chk("m_addr", m_req.addr, mq[0].addr);
            chk("m_we", 32'(m_req.we), 32'(mq[0].we));
            chk("m_be", 32'(m_req.be), 32'(mq[0].be));
            chk("m_wdata", m_req.wdata, mq[0].wdata);
        end
        chk("s_rvalid", 32'(s_resp.rvalid), 32'(m_rvalid));
        chk("s_rdata", s_resp.rdata, m_rdata);
        if (m_rvalid && !m_stray) begin
            chk("order", s_resp.rdata, acc_q.pop_front());
        end
        chk("outstanding", 32'(outst), 32'(m_cnt));
        chk("idle", 32'(idle), 32'(mq.size() == 0 && m_cnt == 0));
        chk("err", 32'(err), 32'(m_err));
        chk("perf", perf, m_perf);

`ifdef CGRA_OBI_SLICE_PERF_EN
        if (mq.size() > 0 && !gnt && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 32'd1;
`endif
        if (from_bus) void'(bus_q.pop_front());
        if (mq.size() > 0 && gnt) begin
            bus_q.push_back(rsp_of(mq[0]));
            void'(mq.pop_front());
        end
        if (exp_gnt) begin
            mq.push_back(e);
            acc_q.push_back(rsp_of(e));
        end
        if (do_rv && m_cnt == 0) m_err = 1'b1;
        m_cnt    = m_cnt + int'(exp_gnt) - int'(do_rv && m_cnt > 0);
        m_stray  = do_rv && !from_bus;
        m_rvalid = do_rv;
        if (do_rv) m_rdata = rv_data;
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (mq.size() > 0 || m_cnt > 0); i++) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        end
        if (mq.size() > 0 || m_cnt > 0) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic apply_reset();
        rst_n  = 1'b0;
        s_req  = '0;
        m_resp = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   dropped;
        logic [31:0] first_addr;

        apply_reset();
        // Reset state
        chk("rst_mreq", 32'(m_req.req), 32'd0);
        chk("rst_rvalid", 32'(s_resp.rvalid), 32'd0);
        chk("rst_rdata", s_resp.rdata, 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cnt", 32'(outst), 32'd0);
        chk("rst_perf", perf, 32'd0);

        // Back-to-back reads, bus always granting and answering next cycle
        dropped = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
            if (!last_gnt) dropped = 1'b1;
        end
        chk("b2b_gnt_drop", 32'(dropped), 32'd0);
        drain();
        chk("b2b_idle", 32'(idle), 32'd1);

        // Bus stall: FIFO fills after two, third request refused, head stable
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        first_addr = mq[0].addr;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_gnt3", 32'(last_gnt), 32'd0);
        chk("stall_addr", m_req.addr, first_addr);
        drain();

        // Outstanding cap
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("cap_cnt", 32'(outst), 32'd4);
        chk("cap_gnt", 32'(last_gnt), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("cap_regnt", 32'(last_gnt), 32'd1);
        drain();

        // Simultaneous accept and response at count 2
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("simul_pre", 32'(outst), 32'd2);
        cycle(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("simul_cnt", 32'(outst), 32'd2);
        drain();

        // Stray response with nothing outstanding
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("stray_err", 32'(err), 32'd1);
        chk("stray_cnt", 32'(outst), 32'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 99) < 60), 1'($urandom_range(0, 99) < 50),
                  1'($urandom_range(0, 99) < 60), 1'b0, 1'b0);
        end
        drain();

        // Reset mid-flight with FIFO=2 and count=3
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mid_pre_cnt", 32'(outst), 32'd3);
        chk("mid_pre_mreq", 32'(m_req.req), 32'd1);
        #2;
        rst_n  = 1'b0;
        s_req  = '0;
        m_resp = '0;
        #1;
        chk("mid_mreq_async", 32'(m_req.req), 32'd0);
        chk("mid_idle", 32'(idle), 32'd1);
        chk("mid_cnt", 32'(outst), 32'd0);
        chk("mid_err", 32'(err), 32'd0);
        chk("mid_rvalid", 32'(s_resp.rvalid), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Stall counter: one buffered request held ungranted for 10 cycles
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef CGRA_OBI_SLICE_PERF_EN
        chk("perf10", perf, 32'd10);
`else
        chk("perf_off", perf, 32'd0);
`endif
        drain();
        chk("end_idle", 32'(idle), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
